dm_sba_arb: RTL and testbench

DM_SBA_ARB -- requirements
Module: dm_sba_arb

---
 rtl/dm_sba_arb_pkg.sv | 12 +
 rtl/dm_sba_arb_if.sv | 19 +
 rtl/dm_sba_arb_fifo.sv | 47 ++++
 rtl/dm_sba_arb.sv | 112 +++++++++++
 tb/tb_dm_sba_arb.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dm_sba_arb_pkg.sv
// rtl/dm_sba_arb_pkg.sv - shared constants and helpers for the system bus arbiter
package dm_sba_arb_pkg;

    localparam int unsigned ByteW = 8;

    // Round-robin candidate: requester index reached by stepping off places from base.
    function automatic int unsigned rr_offset(input int unsigned base, input int unsigned off,
                                              input int unsigned n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/dm_sba_arb_if.sv
// rtl/dm_sba_arb_if.sv - system bus master port bundle driven by the arbiter
interface dm_sba_arb_if #(
    parameter int unsigned BusWidth = 32
);
    import dm_sba_arb_pkg::*;

    logic                      req;
    logic [BusWidth-1:0]       add;
    logic                      we;
    logic [BusWidth-1:0]       wdata;
    logic [BusWidth/ByteW-1:0] be;
    logic                      gnt;
    logic                      r_valid;
    logic [BusWidth-1:0]       r_rdata;

    modport master (output req, add, we, wdata, be, input gnt, r_valid, r_rdata);
    modport slave  (input req, add, we, wdata, be, output gnt, r_valid, r_rdata);

endinterface

// File: rtl/dm_sba_arb_fifo.sv
// rtl/dm_sba_arb_fifo.sv - in-order FIFO of granted requester indices awaiting responses
module dm_sba_arb_fifo #(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [Width-1:0] data_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [Width-1:0] head_o
);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q, rptr_q;
    logic [CntW-1:0]  cnt_q;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rptr_q];
    assign do_pop  = pop_i & ~empty_o;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wptr_q] <= data_i;
                wptr_q <= (wptr_q == PtrW'(Depth - 1)) ? '0 : wptr_q + 1'b1;
            end
            if (do_pop) rptr_q <= (rptr_q == PtrW'(Depth - 1)) ? '0 : rptr_q + 1'b1;
            if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
            else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
        end
    end

endmodule

// File: rtl/dm_sba_arb.sv
// rtl/dm_sba_arb.sv - round-robin arbiter of several requesters onto one system bus master
module dm_sba_arb
    import dm_sba_arb_pkg::*;
#(
    parameter int unsigned BusWidth       = 32,
    parameter int unsigned NumReq         = 2,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic [NumReq-1:0]                      req_i,
    input  logic [NumReq-1:0][BusWidth-1:0]        add_i,
    input  logic [NumReq-1:0]                      we_i,
    input  logic [NumReq-1:0][BusWidth-1:0]        wdata_i,
    input  logic [NumReq-1:0][BusWidth/ByteW-1:0]  be_i,
    output logic [NumReq-1:0]                      gnt_o,
    output logic [NumReq-1:0]                      r_valid_o,
    output logic [BusWidth-1:0]                    r_rdata_o,
    output logic                                   master_req_o,
    output logic [BusWidth-1:0]                    master_add_o,
    output logic                                   master_we_o,
    output logic [BusWidth-1:0]                    master_wdata_o,
    output logic [BusWidth/ByteW-1:0]              master_be_o,
    input  logic                                   master_gnt_i,
    input  logic                                   master_r_valid_i,
    input  logic [BusWidth-1:0]                    master_r_rdata_i,
    output logic                                   rsp_err_o
);
    localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

    logic [IdxW-1:0] rr_q, rr_d, lock_idx_q, lock_idx_d;
    logic            lock_q, lock_d;
    logic [IdxW-1:0] sel_idx, cand, fifo_head;
    logic            sel_valid, grant, fifo_full, fifo_empty, fifo_pop;

    // Selection: a locked requester keeps the bus until granted or it withdraws.
    always_comb begin
        sel_idx   = lock_idx_q;
        sel_valid = 1'b0;
        cand      = rr_q;
        if (lock_q) begin
            sel_valid = req_i[lock_idx_q];
        end else begin
            for (int unsigned i = 0; i < NumReq; i++) begin
                cand = IdxW'(rr_offset(32'(rr_q), i, NumReq));
                if (!sel_valid && req_i[cand]) begin
                    sel_idx   = cand;
                    sel_valid = 1'b1;
                end
            end
        end
    end

    assign fifo_pop     = master_r_valid_i & ~fifo_empty;
    assign grant        = master_gnt_i & sel_valid & (~fifo_full | fifo_pop);
    assign master_req_o = sel_valid & ~fifo_full;
    assign rsp_err_o    = master_r_valid_i & fifo_empty;
    assign r_rdata_o    = master_r_rdata_i;

    always_comb begin
        gnt_o                = '0;
        gnt_o[sel_idx]       = grant;
        r_valid_o            = '0;
        r_valid_o[fifo_head] = fifo_pop;
        master_add_o         = sel_valid ? add_i[sel_idx]   : '0;
        master_we_o          = sel_valid ? we_i[sel_idx]    : 1'b0;
        master_wdata_o       = sel_valid ? wdata_i[sel_idx] : '0;
        master_be_o          = sel_valid ? be_i[sel_idx]    : '0;
    end

    always_comb begin
        rr_d       = rr_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        if (grant) begin
            rr_d   = IdxW'(rr_offset(32'(sel_idx), 1, NumReq));
            lock_d = 1'b0;
        end else if (lock_q && !req_i[lock_idx_q]) begin
            lock_d = 1'b0;
        end else if (!lock_q && master_req_o) begin
            lock_d     = 1'b1;
            lock_idx_d = sel_idx;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q       <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            rr_q       <= rr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
        end
    end

    dm_sba_arb_fifo #(
        .Depth (MaxOutstanding),
        .Width (IdxW)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (grant),
        .pop_i   (master_r_valid_i),
        .data_i  (sel_idx),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (fifo_head)
    );

endmodule

// File: tb/tb_dm_sba_arb.sv
// tb/tb_dm_sba_arb.sv - randomized bench for dm_sba_arb against a queue-based reference model
module tb_dm_sba_arb;
    import dm_sba_arb_pkg::*;

    localparam int NR  = 2;
    localparam int BW  = 32;
    localparam int MO  = 2;
    localparam int BEW = BW / 8;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk = ~clk;

    logic [NR-1:0]          req_i, we_i;
    logic [NR-1:0][BW-1:0]  add_i, wdata_i;
    logic [NR-1:0][BEW-1:0] be_i;
    logic [NR-1:0]          gnt_o, r_valid_o;
    logic [BW-1:0]          r_rdata_o;
    logic                   rsp_err_o;

    dm_sba_arb_if #(.BusWidth(BW)) mbus();

    dm_sba_arb #(
        .BusWidth       (BW),
        .NumReq         (NR),
        .MaxOutstanding (MO)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .req_i            (req_i),
        .add_i            (add_i),
        .we_i             (we_i),
        .wdata_i          (wdata_i),
        .be_i             (be_i),
        .gnt_o            (gnt_o),
        .r_valid_o        (r_valid_o),
        .r_rdata_o        (r_rdata_o),
        .master_req_o     (mbus.req),
        .master_add_o     (mbus.add),
        .master_we_o      (mbus.we),
        .master_wdata_o   (mbus.wdata),
        .master_be_o      (mbus.be),
        .master_gnt_i     (mbus.gnt),
        .master_r_valid_i (mbus.r_valid),
        .master_r_rdata_i (mbus.r_rdata),
        .rsp_err_o        (rsp_err_o)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: next round-robin start, lock owner, outstanding requester queue.
    int m_rr;
    bit m_lock;
    int m_lk;
    int m_q[$];

    logic [NR-1:0] obs_gnt, obs_rv;
    logic          obs_mreq, obs_err;
    logic [BW-1:0] obs_add;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Called just after a rising edge with inputs already applied.
    task automatic cycle();
        int s;
        bit v, full, pop, g, emreq;
        logic [NR-1:0] eg, erv;
        #4;
        s = 0;
        v = 1'b0;
        if (m_lock) begin
            s = m_lk;
            v = req_i[s];
        end else begin
            for (int i = 0; i < NR; i++) begin
                int c;
                c = (m_rr + i) % NR;
                if (!v && req_i[c]) begin
                    s = c;
                    v = 1'b1;
                end
            end
        end
        full  = (m_q.size() >= MO);
        pop   = mbus.r_valid && (m_q.size() > 0);
        g     = mbus.gnt && v && (!full || pop);
        emreq = v && !full;
        eg    = '0;
        erv   = '0;
        if (g)   eg[s] = 1'b1;
        if (pop) erv[m_q[0]] = 1'b1;

        chk("gnt_o", 64'(gnt_o), 64'(eg));
        chk("r_valid_o", 64'(r_valid_o), 64'(erv));
        chk("master_req_o", 64'(mbus.req), 64'(emreq));
        chk("rsp_err_o", 64'(rsp_err_o), 64'(mbus.r_valid && m_q.size() == 0));
        chk("r_rdata_o", 64'(r_rdata_o), 64'(mbus.r_rdata));
        if (v || req_i == '0) begin
            chk("master_add_o", 64'(mbus.add), v ? 64'(add_i[s]) : 64'd0);
            chk("master_we_o", 64'(mbus.we), v ? 64'(we_i[s]) : 64'd0);
            chk("master_wdata_o", 64'(mbus.wdata), v ? 64'(wdata_i[s]) : 64'd0);
            chk("master_be_o", 64'(mbus.be), v ? 64'(be_i[s]) : 64'd0);
        end

        obs_gnt  = gnt_o;
        obs_rv   = r_valid_o;
        obs_mreq = mbus.req;
        obs_err  = rsp_err_o;
        obs_add  = mbus.add;

        if (rst_ni) begin
            if (pop) void'(m_q.pop_front());
            if (g) begin
                m_q.push_back(s);
                m_rr   = (s + 1) % NR;
                m_lock = 1'b0;
            end else if (m_lock && !req_i[m_lk]) begin
                m_lock = 1'b0;
            end else if (!m_lock && emreq) begin
                m_lock = 1'b1;
                m_lk   = s;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [NR-1:0] r, input logic g, input logic rv);
        req_i         = r;
        mbus.gnt      = g;
        mbus.r_valid  = rv;
        mbus.r_rdata  = $urandom;
        cycle();
    endtask

    task automatic do_reset();
        rst_ni       = 1'b0;
        req_i        = '0;
        mbus.gnt     = 1'b0;
        mbus.r_valid = 1'b0;
        m_rr         = 0;
        m_lock       = 1'b0;
        m_lk         = 0;
        m_q.delete();
        cycle();
        rst_ni = 1'b1;
    endtask

    logic [NR-1:0] prev_g;
    logic [NR-1:0] gseq [4];
    logic [NR-1:0] rseq [4];

    initial begin
        req_i        = '0;
        mbus.gnt     = 1'b0;
        mbus.r_valid = 1'b0;
        mbus.r_rdata = '0;
        for (int k = 0; k < NR; k++) begin
            add_i[k]   = 32'h2000_0000 + 32'(k * 16);
            wdata_i[k] = 32'hA5A5_0000 + 32'(k);
            we_i[k]    = k[0];
            be_i[k]    = BEW'(4'hF - k);
        end
        #1;
        do_reset();
        chk("reset_gnt", 64'(obs_gnt), 64'd0);
        chk("reset_rvalid", 64'(obs_rv), 64'd0);
        chk("reset_mreq", 64'(obs_mreq), 64'd0);
        chk("reset_add", 64'(obs_add), 64'd0);

        // Both requesting, granted every cycle, answered one cycle later.
        prev_g = '0;
        for (int c = 0; c < 4; c++) begin
            drive(2'b11, 1'b1, prev_g != '0);
            gseq[c] = obs_gnt;
            rseq[c] = obs_rv;
            prev_g  = obs_gnt;
        end
        chk("alt_g0", 64'(gseq[0]), 64'd1);
        chk("alt_g1", 64'(gseq[1]), 64'd2);
        chk("alt_g2", 64'(gseq[2]), 64'd1);
        chk("alt_g3", 64'(gseq[3]), 64'd2);
        chk("alt_r1", 64'(rseq[1]), 64'd1);
        chk("alt_r2", 64'(rseq[2]), 64'd2);
        chk("alt_r3", 64'(rseq[3]), 64'd1);
        drive(2'b00, 1'b0, 1'b1);
        chk("alt_drain", 64'(obs_rv), 64'd2);

        // Lock holds on requester 1 when requester 0 joins.
        do_reset();
        drive(2'b10, 1'b0, 1'b0);
        chk("lock_add0", 64'(obs_add), 64'h2000_0010);
        drive(2'b11, 1'b0, 1'b0);
        chk("lock_add1", 64'(obs_add), 64'h2000_0010);
        drive(2'b11, 1'b0, 1'b0);
        chk("lock_add2", 64'(obs_add), 64'h2000_0010);
        drive(2'b11, 1'b1, 1'b0);
        chk("lock_gnt", 64'(obs_gnt), 64'd2);
        drive(2'b00, 1'b0, 1'b1);
        chk("lock_rsp", 64'(obs_rv), 64'd2);

        // Fill the FIFO, then exchange one entry while full.
        do_reset();
        drive(2'b11, 1'b1, 1'b0);
        drive(2'b11, 1'b1, 1'b0);
        drive(2'b11, 1'b0, 1'b0);
        chk("full_mreq", 64'(obs_mreq), 64'd0);
        drive(2'b11, 1'b1, 1'b0);
        chk("full_gnt_ignored", 64'(obs_gnt), 64'd0);
        drive(2'b11, 1'b1, 1'b1);
        chk("swap_gnt", 64'(obs_gnt), 64'd1);
        chk("swap_rv", 64'(obs_rv), 64'd1);
        chk("swap_mreq", 64'(obs_mreq), 64'd0);
        drive(2'b11, 1'b0, 1'b1);
        chk("after_swap_rv", 64'(obs_rv), 64'd2);
        chk("after_swap_mreq", 64'(obs_mreq), 64'd0);
        drive(2'b11, 1'b0, 1'b0);
        chk("reassert_mreq", 64'(obs_mreq), 64'd1);
        chk("reassert_add", 64'(obs_add), 64'h2000_0010);
        drive(2'b00, 1'b0, 1'b1);
        chk("last_rv", 64'(obs_rv), 64'd1);

        // Unexpected response with nothing outstanding.
        drive(2'b00, 1'b0, 1'b1);
        chk("err_pulse", 64'(obs_err), 64'd1);
        chk("err_no_rv", 64'(obs_rv), 64'd0);
        drive(2'b00, 1'b0, 1'b0);
        chk("err_cleared", 64'(obs_err), 64'd0);

        // Reset while locked with one transaction outstanding.
        do_reset();
        drive(2'b11, 1'b1, 1'b0);
        drive(2'b11, 1'b0, 1'b0);
        do_reset();
        drive(2'b00, 1'b0, 1'b1);
        chk("post_reset_err", 64'(obs_err), 64'd1);
        drive(2'b11, 1'b1, 1'b0);
        chk("post_reset_gnt", 64'(obs_gnt), 64'd1);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 499) == 0) do_reset();
            if ($urandom_range(0, 3) == 0) req_i = NR'($urandom_range(0, (1 << NR) - 1));
            for (int k = 0; k < NR; k++) begin
                add_i[k]   = $urandom;
                wdata_i[k] = $urandom;
                we_i[k]    = 1'($urandom_range(0, 1));
                be_i[k]    = BEW'($urandom);
            end
            mbus.gnt     = ($urandom_range(0, 2) == 0);
            mbus.r_valid = ($urandom_range(0, 2) == 0);
            mbus.r_rdata = $urandom;
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
